// File: rtl/regfile_pkg.sv
// Shared defines and package for the register file slice.
// Defines ROB_WIDTH / ROB_SIZE / REG_NUM once (guarded) so every file of the
// slice takes them from one place.
// Optional feature macro: REGFILE_DEBUG_EN (see regfile.sv).
`ifndef REGFILE_SHARED_DEFINES
`define REGFILE_SHARED_DEFINES
`define ROB_WIDTH 4
`define ROB_SIZE 16
`define REG_NUM 32
`endif

package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ID_W   = 5;
  localparam int ROB_SIZE_P = `ROB_SIZE;

  // True when the 5-bit register id addresses an implemented register.
  function automatic logic reg_id_ok(input logic [REG_ID_W-1:0] id, input int n);
    return int'(id) < n;
  endfunction

  // x0 is hard-wired; only nonzero, implemented ids may be written.
  function automatic logic reg_writable(input logic [REG_ID_W-1:0] id, input int n);
    return (id != '0) && reg_id_ok(id, n);
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One operand read port: resolves a source register to a ready value or the
// ROB tag it is waiting on. Priority: x0, idle register, same-cycle commit
// bypass, ROB search hit, otherwise not ready.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int ROB_W = `ROB_WIDTH
) (
  input  logic [REG_ID_W-1:0] rs_id,
  input  logic                reg_busy,
  input  logic [XLEN-1:0]     reg_val,
  input  logic [ROB_W-1:0]    reg_dep,
  input  logic                commit_ready,
  input  logic [REG_ID_W-1:0] commit_reg_id,
  input  logic [ROB_W-1:0]    commit_rob_id,
  input  logic [XLEN-1:0]     commit_val,
  input  logic                search_ready,
  input  logic [XLEN-1:0]     search_val,
  output logic                rs_ready,
  output logic [XLEN-1:0]     rs_val,
  output logic [ROB_W-1:0]    rs_dep
);

  // Priority resolution of the operand source.
  always_comb begin
    rs_ready = 1'b0;
    rs_val   = '0;
    rs_dep   = reg_dep;
    if (rs_id == '0) begin
      rs_ready = 1'b1;
      rs_dep   = '0;
    end else if (!reg_busy) begin
      rs_ready = 1'b1;
      rs_val   = reg_val;
    end else if (commit_ready && (commit_reg_id == rs_id) && (commit_rob_id == reg_dep)) begin
      rs_ready = 1'b1;
      rs_val   = commit_val;
    end else if (search_ready) begin
      rs_ready = 1'b1;
      rs_val   = search_val;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags (busy/dep per register),
// two combinational read ports with commit bypass and ROB search, commit
// write-back and mispredict flush.
// Optional feature macro: REGFILE_DEBUG_EN adds output dbg_a0 (= x10) and a
// simulation print of every commit.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = `REG_NUM,
  parameter int ROB_W   = `ROB_WIDTH
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                dec_ready,
  input  logic [REG_ID_W-1:0] rd,
  input  logic [ROB_W-1:0]    empty_rob_id,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic                rs1_ready,
  output logic [XLEN-1:0]     rs1_val,
  output logic [ROB_W-1:0]    rs1_dep,
  output logic                rs2_ready,
  output logic [XLEN-1:0]     rs2_val,
  output logic [ROB_W-1:0]    rs2_dep,
  input  logic                commit_ready,
  input  logic [ROB_W-1:0]    commit_rob_id,
  input  logic [REG_ID_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]     commit_val,
  output logic [ROB_W-1:0]    search_rob_id_1,
  input  logic                search_ready_1,
  input  logic [XLEN-1:0]     search_val_1,
  output logic [ROB_W-1:0]    search_rob_id_2,
  input  logic                search_ready_2,
  input  logic [XLEN-1:0]     search_val_2,
  input  logic                clear
`ifdef REGFILE_DEBUG_EN
  ,output logic [XLEN-1:0]    dbg_a0
`endif
);

  logic [XLEN-1:0]  val_q  [REG_NUM];
  logic             busy_q [REG_NUM];
  logic [ROB_W-1:0] dep_q  [REG_NUM];

  logic             busy_1, busy_2;
  logic [XLEN-1:0]  val_1, val_2;
  logic [ROB_W-1:0] dep_1, dep_2;

  logic do_commit;
  logic do_rename;

  assign do_commit = commit_ready && reg_writable(commit_reg_id, REG_NUM);
  // A flush squashes the instruction being renamed in the same cycle.
  assign do_rename = dec_ready && !clear && reg_writable(rd, REG_NUM);

  // Fetch the addressed entries for both read ports (pre-edge state).
  always_comb begin
    busy_1 = 1'b0;
    val_1  = '0;
    dep_1  = '0;
    busy_2 = 1'b0;
    val_2  = '0;
    dep_2  = '0;
    if (reg_id_ok(rs1_id, REG_NUM)) begin
      busy_1 = busy_q[rs1_id];
      val_1  = val_q[rs1_id];
      dep_1  = dep_q[rs1_id];
    end
    if (reg_id_ok(rs2_id, REG_NUM)) begin
      busy_2 = busy_q[rs2_id];
      val_2  = val_q[rs2_id];
      dep_2  = dep_q[rs2_id];
    end
  end

  assign search_rob_id_1 = dep_1;
  assign search_rob_id_2 = dep_2;

  regfile_read_port #(.ROB_W(ROB_W)) u_read_port_1 (
    .rs_id         (rs1_id),
    .reg_busy      (busy_1),
    .reg_val       (val_1),
    .reg_dep       (dep_1),
    .commit_ready  (commit_ready),
    .commit_reg_id (commit_reg_id),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
    .search_ready  (search_ready_1),
    .search_val    (search_val_1),
    .rs_ready      (rs1_ready),
    .rs_val        (rs1_val),
    .rs_dep        (rs1_dep)
  );

  regfile_read_port #(.ROB_W(ROB_W)) u_read_port_2 (
    .rs_id         (rs2_id),
    .reg_busy      (busy_2),
    .reg_val       (val_2),
    .reg_dep       (dep_2),
    .commit_ready  (commit_ready),
    .commit_reg_id (commit_reg_id),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
    .search_ready  (search_ready_2),
    .search_val    (search_val_2),
    .rs_ready      (rs2_ready),
    .rs_val        (rs2_val),
    .rs_dep        (rs2_dep)
  );

  // All register state: flush, then commit, then rename. Later non-blocking
  // writes win, so a same-cycle rename of the committed register keeps it
  // busy under the new tag while the committed value still lands.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        dep_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
        end
      end
      if (do_commit) begin
        val_q[commit_reg_id] <= commit_val;
        // An older producer committing must not release a newer rename.
        if (!clear && (dep_q[commit_reg_id] == commit_rob_id)) begin
          busy_q[commit_reg_id] <= 1'b0;
        end
      end
      if (do_rename) begin
        busy_q[rd] <= 1'b1;
        dep_q[rd]  <= empty_rob_id;
      end
    end
  end

`ifdef REGFILE_DEBUG_EN
  assign dbg_a0 = val_q[10];

  // Trace of every committed write-back.
  always @(posedge clk_in) begin
    if (rst_in && rdy_in && do_commit) begin
      $display("commit x%0d = %h", commit_reg_id, commit_val);
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
  localparam int ROB_W = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_ready;
  logic [4:0]  rd;
  logic [ROB_W-1:0] empty_rob_id;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;
  logic [ROB_W-1:0] rs1_dep, rs2_dep;
  logic        commit_ready;
  logic [ROB_W-1:0] commit_rob_id;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_val;
  logic [ROB_W-1:0] search_rob_id_1, search_rob_id_2;
  logic        search_ready_1, search_ready_2;
  logic [31:0] search_val_1, search_val_2;
  logic        clear;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  regfile #(.REG_NUM(32), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_ready(dec_ready), .rd(rd), .empty_rob_id(empty_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_dep(rs1_dep),
    .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_dep(rs2_dep),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
    .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
    .clear(clear)
  );

  always #5 clk_in = ~clk_in;

  // Architectural model: what each register holds, whether it awaits a tag.
  logic [31:0]      m_val  [32];
  logic             m_busy [32];
  logic [ROB_W-1:0] m_dep  [32];

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_dep[i] = 0;
      end
    end else if (rdy_in) begin
      if (commit_ready && commit_reg_id != 0) begin
        m_val[commit_reg_id] = commit_val;
        if (m_dep[commit_reg_id] == commit_rob_id) m_busy[commit_reg_id] = 0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (dec_ready && rd != 0) begin
        m_busy[rd] = 1;
        m_dep[rd]  = empty_rob_id;
      end
    end
  end

  function automatic void exp_read(input logic [4:0] id, input logic sr, input logic [31:0] sv,
                                   output logic r, output logic [31:0] v, output logic [ROB_W-1:0] d);
    d = m_dep[id];
    if (id == 0) begin r = 1; v = 0; d = 0; end
    else if (!m_busy[id]) begin r = 1; v = m_val[id]; end
    else if (commit_ready && commit_reg_id == id && commit_rob_id == m_dep[id]) begin r = 1; v = commit_val; end
    else if (sr) begin r = 1; v = sv; end
    else begin r = 0; v = 0; end
  endfunction

  // Per-cycle comparison of both read ports and search tags against the model.
  always @(negedge clk_in) begin
    logic er; logic [31:0] ev; logic [ROB_W-1:0] ed;
    if (cmp_en) begin
      exp_read(rs1_id, search_ready_1, search_val_1, er, ev, ed);
      checks++;
      if (rs1_ready !== er || rs1_val !== ev || (!er && rs1_dep !== ed)) begin
        errors++;
        $display("FAIL model_rs1 t=%0t id=%0d got rdy=%b val=%h dep=%h exp rdy=%b val=%h dep=%h",
                 $time, rs1_id, rs1_ready, rs1_val, rs1_dep, er, ev, ed);
      end
      checks++;
      if (search_rob_id_1 !== m_dep[rs1_id]) begin
        errors++;
        $display("FAIL model_search1 t=%0t got %h exp %h", $time, search_rob_id_1, m_dep[rs1_id]);
      end
      exp_read(rs2_id, search_ready_2, search_val_2, er, ev, ed);
      checks++;
      if (rs2_ready !== er || rs2_val !== ev || (!er && rs2_dep !== ed)) begin
        errors++;
        $display("FAIL model_rs2 t=%0t id=%0d got rdy=%b val=%h dep=%h exp rdy=%b val=%h dep=%h",
                 $time, rs2_id, rs2_ready, rs2_val, rs2_dep, er, ev, ed);
      end
      checks++;
      if (search_rob_id_2 !== m_dep[rs2_id]) begin
        errors++;
        $display("FAIL model_search2 t=%0t got %h exp %h", $time, search_rob_id_2, m_dep[rs2_id]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic idle_inputs();
    dec_ready = 0; rd = 0; empty_rob_id = 0;
    commit_ready = 0; commit_reg_id = 0; commit_rob_id = 0; commit_val = 0;
    search_ready_1 = 0; search_val_1 = 0; search_ready_2 = 0; search_val_2 = 0;
    clear = 0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [ROB_W-1:0] tag);
    dec_ready = 1; rd = r; empty_rob_id = tag;
  endtask

  task automatic commit(input logic [4:0] r, input logic [ROB_W-1:0] tag, input logic [31:0] v);
    commit_ready = 1; commit_reg_id = r; commit_rob_id = tag; commit_val = v;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 0; rdy_in = 1; rs1_id = 0; rs2_id = 0;
    idle_inputs();
    repeat (3) step();
    rst_in = 1;
    cmp_en = 1;

    // Reset state
    rs1_id = 5; rs2_id = 31; look();
    chk("reset_rs1_ready", {31'b0, rs1_ready}, 1);
    chk("reset_rs1_val", rs1_val, 0);
    chk("reset_rs2_ready", {31'b0, rs2_ready}, 1);

    // Rename x5 -> tag 3, then search path
    rename(5, 3); step(); idle_inputs(); look();
    chk("ren_rs1_ready", {31'b0, rs1_ready}, 0);
    chk("ren_rs1_dep", {28'b0, rs1_dep}, 3);
    chk("ren_search_id", {28'b0, search_rob_id_1}, 3);
    search_ready_1 = 1; search_val_1 = 32'h2A; look();
    chk("search_ready", {31'b0, rs1_ready}, 1);
    chk("search_val", rs1_val, 32'h2A);
    search_ready_1 = 0;

    // Commit x5 tag 3: bypass same cycle, architectural next cycle
    step(); commit(5, 3, 32'h11); look();
    chk("bypass_ready", {31'b0, rs1_ready}, 1);
    chk("bypass_val", rs1_val, 32'h11);
    step(); idle_inputs(); look();
    chk("commit_ready_after", {31'b0, rs1_ready}, 1);
    chk("commit_val_after", rs1_val, 32'h11);

    // rd == rs sees older producer
    step(); rename(5, 2); look();
    chk("self_dep_ready", {31'b0, rs1_ready}, 1);
    chk("self_dep_val", rs1_val, 32'h11);
    step(); idle_inputs(); look();
    chk("self_dep_next_dep", {28'b0, rs1_dep}, 2);

    // Older commit does not release newer rename
    rename(7, 4); step(); rename(7, 6); step(); idle_inputs();
    commit(7, 4, 32'h99); rs2_id = 7; look();
    chk("stale_commit_nobypass", {31'b0, rs2_ready}, 0);
    step(); idle_inputs(); look();
    chk("stale_busy", {31'b0, rs2_ready}, 0);
    chk("stale_dep", {28'b0, rs2_dep}, 6);

    // Flush with commit and rename in the same cycle
    rename(8, 1); step(); rename(9, 5); step(); idle_inputs();
    rs1_id = 8; rs2_id = 9; look();
    chk("pre_clear_x8_busy", {31'b0, rs1_ready}, 0);
    chk("pre_clear_x9_busy", {31'b0, rs2_ready}, 0);
    clear = 1; commit(8, 7, 32'h55); rename(9, 8);
    step(); idle_inputs(); look();
    chk("clear_x8_ready", {31'b0, rs1_ready}, 1);
    chk("clear_x8_val", rs1_val, 32'h55);
    chk("clear_x9_ready", {31'b0, rs2_ready}, 1);
    chk("clear_x9_val", rs2_val, 0);
    rs1_id = 7; rs2_id = 5; look();
    chk("clear_x7_val", rs1_val, 32'h99);
    chk("clear_x5_val", rs2_val, 32'h11);

    // Same-cycle rename and commit to one register
    step(); rename(10, 9); commit(10, 0, 32'h77); rs1_id = 10;
    step(); idle_inputs(); look();
    chk("rc_same_busy", {31'b0, rs1_ready}, 0);
    chk("rc_same_dep", {28'b0, rs1_dep}, 9);
    commit(10, 9, 32'h78); look();
    chk("rc_bypass_val", rs1_val, 32'h78);
    step(); idle_inputs(); look();
    chk("rc_final_val", rs1_val, 32'h78);

    // Stall holds state
    rdy_in = 0; rename(11, 1); commit(5, 0, 32'hBAD); rs1_id = 11; rs2_id = 5;
    step(); rdy_in = 1; idle_inputs(); look();
    chk("stall_x11_ready", {31'b0, rs1_ready}, 1);
    chk("stall_x5_val", rs2_val, 32'h11);

    // x0 never written
    rename(0, 5); commit(0, 0, 32'hDEAD); rs1_id = 0; look();
    chk("x0_same_val", rs1_val, 0);
    step(); idle_inputs(); look();
    chk("x0_ready", {31'b0, rs1_ready}, 1);
    chk("x0_val", rs1_val, 0);
    chk("x0_search", {28'b0, search_rob_id_1}, 0);

    // Async reset in the middle of a rename
    rename(12, 3); step(); idle_inputs(); rs1_id = 12; rs2_id = 5; look();
    chk("pre_rst_x12_busy", {31'b0, rs1_ready}, 0);
    rename(13, 4); #1; rst_in = 0; #1;
    chk("rst_x12_ready", {31'b0, rs1_ready}, 1);
    chk("rst_x5_val", rs2_val, 0);
    chk("rst_x5_ready", {31'b0, rs2_ready}, 1);
    step(); step(); idle_inputs(); rst_in = 1;
    rs1_id = 13; rs2_id = 8; look();
    chk("post_rst_x13_ready", {31'b0, rs1_ready}, 1);
    chk("post_rst_x8_val", rs2_val, 0);
    step(); step();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, meaning the architectural register count; x0 is hard-wired to zero.
REQ-002 SHALL have parameter ROB_W, default `ROB_WIDTH (4), meaning the ROB tag width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_in  in  1  system clock; rst_in  in  1  asynchronous active-low reset.
REQ-004 SHALL have port rdy_in  in  1  global stall; state holds while low.
REQ-005 SHALL have decoder rename ports dec_ready in 1, rd in 5, and empty_rob_id in ROB_W (tag allocated to rd).
REQ-006 SHALL have decoder read ports rs1_id/rs2_id in 5 and, per port n=1,2: rsn_ready out 1, rsn_val out 32, rsn_dep out ROB_W.
REQ-007 SHALL have commit ports commit_ready in 1, commit_rob_id in ROB_W, commit_reg_id in 5, commit_val in 32.
REQ-008 SHALL have ROB search ports search_rob_id_n out ROB_W, search_ready_n in 1, search_val_n in 32, for n=1,2.
REQ-009 SHALL have flush port clear in 1 (mispredict; one cycle).

Function
REQ-010 SHALL hold per register val[32], busy[1], dep[ROB_W].
REQ-011 SHALL drive search_rob_id_n = dep[rsn_id] combinationally.
REQ-012 SHALL compute each read port combinationally, in priority order: rsn_id==0 -> ready=1, val=0; !busy -> ready=1, val=val[rsn_id]; commit_ready && commit_reg_id==rsn_id && commit_rob_id==dep -> ready=1, val=commit_val; search_ready_n -> ready=1, val=search_val_n; else ready=0, val=0, dep=dep[rsn_id].
REQ-013 SHALL base reads on pre-edge state, so an instruction whose rd equals its rs sees the older producer.
REQ-014 SHALL, on rename at the edge when rdy_in && dec_ready && rd!=0 && !clear, set busy[rd]<=1 and dep[rd]<=empty_rob_id.
REQ-015 SHALL, on commit at the edge when rdy_in && commit_ready && commit_reg_id!=0, set val<=commit_val; busy<=0 only if dep==commit_rob_id.
REQ-016 SHALL, on same-cycle rename and commit to the same rd, apply val<=commit_val and keep busy=1 with the new dep.
REQ-017 SHALL, on clear && rdy_in, clear all busy bits, still apply that cycle's commit value write, and ignore that cycle's rename.
REQ-018 SHALL never write x0; every access to x0 reads 0/ready.
REQ-019 SHALL update no state while rdy_in=0; read outputs remain combinational.
REQ-020 SHALL have zero-cycle read latency and one-cycle rename/commit visibility.

Reset
REQ-021 SHALL, while rst_in=0, asynchronously clear all val, busy and dep to 0; reset overrides rdy_in and clear.
REQ-022 SHALL, after reset release, report every register ready with value 0.

Configuration
REQ-023 SHALL, with REGFILE_DEBUG_EN defined, add output dbg_a0 [31:0] (= val[10]) and print "commit x<id> = <hex>" on each commit.
REQ-024 SHALL, without REGFILE_DEBUG_EN, have neither the port nor the print; functional behaviour is identical.

Structure
REQ-025 SHALL take ROB_WIDTH, ROB_SIZE and REG_NUM from the shared defines header; no local redefinition.
REQ-026 SHALL implement the REQ-012 priority mux as sub-module regfile_read_port, instantiated twice.
REQ-027 SHALL use a single sequential block for all state.

Verification
REQ-028 Reset, then read rs1=5 -> ready=1, val=0.
REQ-029 Rename rd=5 tag=3; next cycle read rs1=5, search_ready_1=0 -> ready=0, dep=3, search_rob_id_1=3; with search_ready_1=1, val=0x2A -> ready=1, val=0x2A.
REQ-030 Commit reg 5, tag 3, val 0x11 while dep=3 -> reg 5 not busy, reads 0x11; same-cycle read through bypass already returns 0x11.
REQ-031 Rename rd=7 tag=4, then rename rd=7 tag=6, then commit reg 7 tag 4 val 0x99 -> val=0x99 but busy stays 1, dep=6.
REQ-032 Make x8 and x9 busy, then assert clear with a commit to x8 of 0x55 and a rename of x9 -> all regs ready, x8=0x55, x9 not busy.
REQ-033 Rename or commit with rd=0 -> x0 reads 0/ready; assert rst_in=0 mid-rename -> all state cleared immediately.
